// File: rtl/instr_fetch_mem.sv
// Byte-loadable instruction memory with a one-deep valid/ready fetch port.
// Define IMEM_FAULT_CHECK_EN to flag misaligned or out-of-range fetches.
module instr_fetch_mem #(
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0040_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_inst,
  input  logic              resp_ready,
  input  logic              flush,
  output logic              resp_err
);

  localparam int                IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [7:0]        mem [DEPTH];
  logic              handshake;
  logic [ADDR_W-1:0] load_off;
  logic [ADDR_W-1:0] pc_off;
  logic              load_in_range;
  logic [IDX_W-1:0]  load_idx;
  logic [IDX_W-1:0]  word_idx;
  logic [31:0]       fetch_word;
  logic [31:0]       fetch_inst;
  logic              fetch_err;
  logic              unused_bits;

  // Address translation: byte offset from the base, truncated to the storage size.
  assign load_off      = load_addr - BASE_ADDR;
  assign load_in_range = (load_addr >= BASE_ADDR) && (load_off < DEPTH_A);
  assign load_idx      = load_off[IDX_W-1:0];

  assign pc_off      = req_pc - BASE_ADDR;
  assign word_idx    = {pc_off[IDX_W-1:2], 2'b00};
  assign unused_bits = ^{pc_off[ADDR_W-1:IDX_W], pc_off[1:0]};

  // NOTE: storage is deliberately not reset, so it maps onto RAM and keeps the program across a reset pulse.
  always_ff @(posedge clk) begin
    if (load_we && load_in_range) begin
      mem[load_idx] <= load_data;
    end
  end

  // Little-endian word; the IDX_W-bit sums wrap modulo DEPTH at the storage end.
  assign fetch_word = {mem[word_idx + IDX_W'(3)], mem[word_idx + IDX_W'(2)],
                       mem[word_idx + IDX_W'(1)], mem[word_idx]};

`ifdef IMEM_FAULT_CHECK_EN
  assign fetch_err  = (req_pc[1:0] != 2'b00) || (req_pc < BASE_ADDR) ||
                      (pc_off > (DEPTH_A - ADDR_W'(4)));
  assign fetch_inst = fetch_err ? 32'h0000_0000 : fetch_word;
`else
  assign fetch_err  = 1'b0;
  assign fetch_inst = fetch_word;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the default assignment up front keeps this block purely combinational (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load_we) begin
          state_next = LOAD;
        end else if (handshake) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (load_we) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (!load_we) begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Loads win over fetches by withholding ready; reset also holds ready low.
  always_comb begin
    req_ready = reset && (state != LOAD) && !load_we && (!resp_valid || resp_ready);
  end

  assign handshake = req_valid && req_ready;

  // Flush outranks a same-cycle request; a stalled response holds its payload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_inst  <= 32'h0000_0000;
      resp_err   <= 1'b0;
    end else if (flush) begin
      resp_valid <= 1'b0;
    end else if (handshake) begin
      resp_valid <= 1'b1;
      resp_inst  <= fetch_inst;
      resp_err   <= fetch_err;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Self-checking bench for instr_fetch_mem: directed vector table, corner sequences,
// then randomized traffic against a transaction-level model.
module tb_instr_fetch_mem;

  localparam int unsigned DEPTH = 1024;
  localparam int          IDX_W = 10;
  localparam logic [31:0] BASE  = 32'h0040_0000;
`ifdef IMEM_FAULT_CHECK_EN
  localparam bit FAULT = 1'b1;
`else
  localparam bit FAULT = 1'b0;
`endif

  typedef struct packed {
    logic        err;
    logic [31:0] inst;
  } fetch_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } ld_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_we;
  logic [31:0] load_addr;
  logic [7:0]  load_data;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic        resp_ready;
  logic        flush;
  logic        resp_err;

  int checks   = 0;
  int failures = 0;
  logic [7:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  instr_fetch_mem dut (
    .clk        (clk),
    .reset      (reset),
    .load_we    (load_we),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .req_valid  (req_valid),
    .req_pc     (req_pc),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_inst  (resp_inst),
    .resp_ready (resp_ready),
    .flush      (flush),
    .resp_err   (resp_err)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic in_store(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < DEPTH);
  endfunction

  // Expected fetch result from the storage rules: aligned word, little-endian, wrapping.
  function automatic fetch_t model_fetch(input logic [31:0] pc);
    fetch_t      r;
    int unsigned off;
    int unsigned idx;
    off = pc - BASE;
    idx = (off % DEPTH) & ~32'd3;
    if (FAULT && ((pc[1:0] != 2'b00) || (pc < BASE) || (pc > BASE + DEPTH - 4))) begin
      r.err  = 1'b1;
      r.inst = 32'h0000_0000;
    end else begin
      r.err  = 1'b0;
      r.inst = {model_mem[IDX_W'((idx + 3) % DEPTH)], model_mem[IDX_W'((idx + 2) % DEPTH)],
                model_mem[IDX_W'((idx + 1) % DEPTH)], model_mem[IDX_W'(idx)]};
    end
    return r;
  endfunction

  function automatic vec_t mkv(input string n, input logic [31:0] pc,
                               input logic [31:0] inst, input logic err);
    vec_t v;
    v.name = n; v.pc = pc; v.inst = inst; v.err = err;
    return v;
  endfunction

  function automatic ld_t mkl(input logic [31:0] a, input logic [7:0] d);
    ld_t l;
    l.addr = a; l.data = d;
    return l;
  endfunction

  task automatic load_byte(input logic [31:0] a, input logic [7:0] d);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    req_valid = 1'b1;
    req_pc    = BASE + 32'h28;
    #1 check_bit("ready_low_during_load", req_ready, 1'b0);
    if (in_store(a)) model_mem[IDX_W'(a - BASE)] = d;
    tick();
  endtask

  task automatic fetch_one(input string name, input logic [31:0] pc,
                           input logic [31:0] exp_inst, input logic exp_err);
    req_valid  = 1'b1;
    req_pc     = pc;
    resp_ready = 1'b1;
    #1 check_bit({name, "_ready"}, req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    check_bit({name, "_valid"}, resp_valid, 1'b1);
    check({name, "_inst"}, resp_inst, exp_inst);
    check_bit({name, "_err"}, resp_err, exp_err);
    tick();
    check_bit({name, "_drain"}, resp_valid, 1'b0);
  endtask

  initial begin
    vec_t        vecs [8];
    ld_t         loads [18];
    bit          exp_v;
    bit          exp_ready;
    bit          prev_load;
    fetch_t      exp_r;

    vecs[0] = mkv("vec_base28",   BASE + 32'h28,  32'h8d09_0000, 1'b0);
    vecs[1] = mkv("vec_base2c",   BASE + 32'h2C,  32'h00a0_0513, 1'b0);
    vecs[2] = mkv("vec_first",    BASE,           32'h1234_5678, 1'b0);
    vecs[3] = mkv("vec_last",     BASE + 32'h3FC, 32'hdead_beef, 1'b0);
    vecs[4] = mkv("vec_misalign", 32'h0040_002A,  FAULT ? 32'h0 : 32'h8d09_0000, FAULT);
    vecs[5] = mkv("vec_below",    32'h003F_FFFC,  FAULT ? 32'h0 : 32'hdead_beef, FAULT);
    vecs[6] = mkv("vec_above",    32'h0040_0400,  FAULT ? 32'h0 : 32'h1234_5678, FAULT);
    vecs[7] = mkv("vec_last_mis", 32'h0040_03FE,  FAULT ? 32'h0 : 32'hdead_beef, FAULT);

    loads[0]  = mkl(BASE + 32'h28,  8'h00);
    loads[1]  = mkl(BASE + 32'h29,  8'h00);
    loads[2]  = mkl(BASE + 32'h2A,  8'h09);
    loads[3]  = mkl(BASE + 32'h2B,  8'h8d);
    loads[4]  = mkl(BASE + 32'h2C,  8'h13);
    loads[5]  = mkl(BASE + 32'h2D,  8'h05);
    loads[6]  = mkl(BASE + 32'h2E,  8'ha0);
    loads[7]  = mkl(BASE + 32'h2F,  8'h00);
    loads[8]  = mkl(BASE + 32'h00,  8'h78);
    loads[9]  = mkl(BASE + 32'h01,  8'h56);
    loads[10] = mkl(BASE + 32'h02,  8'h34);
    loads[11] = mkl(BASE + 32'h03,  8'h12);
    loads[12] = mkl(BASE + 32'h3FC, 8'hef);
    loads[13] = mkl(BASE + 32'h3FD, 8'hbe);
    loads[14] = mkl(BASE + 32'h3FE, 8'had);
    loads[15] = mkl(BASE + 32'h3FF, 8'hde);
    loads[16] = mkl(32'h0040_0400,  8'hff);
    loads[17] = mkl(32'h003F_FFFF,  8'hff);

    // Reset state, with a request pending so ready gating is visible.
    reset      = 1'b0;
    load_we    = 1'b0;
    load_addr  = 32'h0;
    load_data  = 8'h0;
    req_valid  = 1'b1;
    req_pc     = BASE;
    resp_ready = 1'b1;
    flush      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("rst_req_ready", req_ready, 1'b0);
    check_bit("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_inst", resp_inst, 32'h0);
    check_bit("rst_resp_err", resp_err, 1'b0);
    req_valid = 1'b0;
    reset     = 1'b1;
    #1 check_bit("ready_after_release", req_ready, 1'b1);
    tick();

    for (int i = 0; i < 18; i++) load_byte(loads[i].addr, loads[i].data);
    load_we   = 1'b0;
    req_valid = 1'b1;
    req_pc    = BASE + 32'h28;
    #1 check_bit("ready_low_load_exit", req_ready, 1'b0);
    tick();
    check_bit("no_resp_load_exit", resp_valid, 1'b0);
    req_valid = 1'b0;

    for (int i = 0; i < 8; i++) fetch_one(vecs[i].name, vecs[i].pc, vecs[i].inst, vecs[i].err);

    // Back-to-back fetches with no bubble.
    req_valid = 1'b1;
    req_pc    = BASE + 32'h28;
    tick();
    check_bit("b2b_v0", resp_valid, 1'b1);
    check("b2b_i0", resp_inst, 32'h8d09_0000);
    req_pc = BASE + 32'h2C;
    #1 check_bit("b2b_ready", req_ready, 1'b1);
    tick();
    check_bit("b2b_v1", resp_valid, 1'b1);
    check("b2b_i1", resp_inst, 32'h00a0_0513);
    req_valid = 1'b0;
    tick();
    check_bit("b2b_drain", resp_valid, 1'b0);

    // Consumer stalls three cycles, then drains and the held request goes through.
    req_valid = 1'b1;
    req_pc    = BASE + 32'h28;
    tick();
    check_bit("stall_first", resp_valid, 1'b1);
    req_pc     = BASE + 32'h2C;
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check_bit("stall_ready", req_ready, 1'b0);
      tick();
      check_bit("stall_valid", resp_valid, 1'b1);
      check("stall_inst", resp_inst, 32'h8d09_0000);
    end
    resp_ready = 1'b1;
    #1 check_bit("stall_release_ready", req_ready, 1'b1);
    tick();
    check_bit("stall_next_valid", resp_valid, 1'b1);
    check("stall_next_inst", resp_inst, 32'h00a0_0513);
    req_valid = 1'b0;
    tick();
    check_bit("stall_drain", resp_valid, 1'b0);

    // Flush alongside a new request: response cleared and request dropped.
    req_valid = 1'b1;
    req_pc    = BASE + 32'h2C;
    tick();
    check_bit("flush_pending", resp_valid, 1'b1);
    flush  = 1'b1;
    req_pc = BASE + 32'h28;
    tick();
    check_bit("flush_valid", resp_valid, 1'b0);
    flush     = 1'b0;
    req_valid = 1'b0;
    tick();
    check_bit("flush_no_late", resp_valid, 1'b0);

    // Asynchronous reset while a response is held; storage survives.
    req_valid = 1'b1;
    req_pc    = BASE + 32'h28;
    tick();
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    check_bit("rp_before", resp_valid, 1'b1);
    reset = 1'b0;
    #1;
    check_bit("rp_valid", resp_valid, 1'b0);
    check("rp_inst", resp_inst, 32'h0);
    check_bit("rp_ready", req_ready, 1'b0);
    #1 reset = 1'b1;
    resp_ready = 1'b1;
    tick();
    check_bit("rp_idle", resp_valid, 1'b0);
    fetch_one("rp_refetch", BASE + 32'h28, 32'h8d09_0000, 1'b0);

    // Fill the whole store with random bytes, then random traffic against the model.
    for (int i = 0; i < int'(DEPTH); i++) load_byte(BASE + 32'(i), 8'($urandom));
    load_we   = 1'b0;
    req_valid = 1'b0;
    tick();

    exp_v     = 1'b0;
    prev_load = 1'b0;
    exp_r     = '0;
    for (int c = 0; c < 2500; c++) begin
      load_we   = ($urandom_range(0, 15) == 0);
      load_addr = ($urandom_range(0, 7) == 0) ? $urandom : BASE + $urandom_range(0, DEPTH - 1);
      load_data = 8'($urandom);
      req_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) req_pc = $urandom;
      else req_pc = BASE + ($urandom_range(0, DEPTH / 4 - 1) * 4) +
                    (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      #1;
      exp_ready = !prev_load && !load_we && (!exp_v || resp_ready);
      check_bit("rnd_req_ready", req_ready, exp_ready);
      if (flush) begin
        exp_v = 1'b0;
      end else if (req_valid && exp_ready) begin
        exp_v = 1'b1;
        exp_r = model_fetch(req_pc);
      end else if (resp_ready) begin
        exp_v = 1'b0;
      end
      if (load_we && in_store(load_addr)) model_mem[IDX_W'(load_addr - BASE)] = load_data;
      prev_load = load_we;
      tick();
      check_bit("rnd_resp_valid", resp_valid, exp_v);
      if (exp_v) begin
        check("rnd_resp_inst", resp_inst, exp_r.inst);
        check_bit("rnd_resp_err", resp_err, exp_r.err);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
